// File: rtl/pipelined_cla_adder_pkg.sv
// pipelined_cla_adder_pkg: mode encodings and segment-count helper for the pipelined CLA adder
package pipelined_cla_adder_pkg;
   localparam logic [1:0] MODE_WRAP = 2'b00;
   localparam logic [1:0] MODE_SSAT = 2'b01;
   localparam logic [1:0] MODE_USAT = 2'b10;
   function automatic int num_seg(input int width, input int seg_width);
      return width / seg_width;
   endfunction
endpackage

// File: rtl/pipelined_cla_adder_cla_segment.sv
// cla_segment: combinational flat carry-lookahead slice of SEG_WIDTH bits
module cla_segment
   import pipelined_cla_adder_pkg::*;
#(
   parameter int SEG_WIDTH = 4
) (
   input  logic [SEG_WIDTH-1:0] a,
   input  logic [SEG_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [SEG_WIDTH-1:0] sum,
   output logic                 cout,
   output logic                 c_msb
);
   logic [SEG_WIDTH-1:0] g, p;
   logic [SEG_WIDTH:0] c;
   logic t, cc;
   assign g = a & b;
   assign p = a ^ b;
   always_comb begin
      t = 1'b0;
      cc = 1'b0;
      c = '0;
      c[0] = cin;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         cc = cin;
         for (int j = 0; j <= i; j++) cc = cc & p[j];
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int l = j + 1; l <= i; l++) t = t & p[l];
            cc = cc | t;
         end
         c[i+1] = cc;
      end
   end
   assign sum = p ^ c[SEG_WIDTH-1:0];
   assign cout = c[SEG_WIDTH];
   assign c_msb = c[SEG_WIDTH-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: one lookahead segment per stage, skewed operands, saturating output register
module pipelined_cla_adder
   import pipelined_cla_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int N = num_seg(WIDTH, SEG_WIDTH);
   localparam int SW = SEG_WIDTH;
   if (SW < 1 || WIDTH < SW || WIDTH % SW != 0) begin : g_param_check
      $error("WIDTH must be a nonzero multiple of SEG_WIDTH");
   end
   logic en, v;
   logic [N-1:0] vld, rc, xc, rmsb, xmsb, seg_c, seg_cm;
   logic [N:0] vsh;
   logic [WIDTH-1:0] ra [N], rb [N], rs [N], xa [N], xb [N], xs [N], ns [N];
   logic [1:0] rm [N], xm [N];
   logic [WIDTH-1:0] seg_sum, sat_s;
   assign en = !out_valid || out_ready;
   assign in_ready = en;
   assign out_valid = vld[N-1];
   assign vsh = {vld, in_valid};
   always_comb begin
      xa[0] = a;
      xb[0] = b;
      xs[0] = '0;
      xc[0] = cin;
      xm[0] = mode;
      xmsb[0] = a[WIDTH-1];
      for (int k = 1; k < N; k++) begin
         xa[k] = ra[k-1];
         xb[k] = rb[k-1];
         xs[k] = rs[k-1];
         xc[k] = rc[k-1];
         xm[k] = rm[k-1];
         xmsb[k] = rmsb[k-1];
      end
   end
   for (genvar i = 0; i < N; i++) begin : g_seg
      cla_segment #(.SEG_WIDTH(SW)) u_seg (
         .a(xa[i][i*SW +: SW]),
         .b(xb[i][i*SW +: SW]),
         .cin(xc[i]),
         .sum(seg_sum[i*SW +: SW]),
         .cout(seg_c[i]),
         .c_msb(seg_cm[i])
      );
   end
   always_comb begin
      for (int k = 0; k < N; k++) begin
         ns[k] = xs[k];
         ns[k][k*SW +: SW] = seg_sum[k*SW +: SW];
      end
   end
   // saturation keys off the original operand MSB carried down the skew path
   assign v = seg_cm[N-1] ^ seg_c[N-1];
   assign sat_s = (xm[N-1] == MODE_SSAT && v) ? {xmsb[N-1], {(WIDTH-1){!xmsb[N-1]}}} :
                  (xm[N-1] == MODE_USAT && seg_c[N-1]) ? '1 : ns[N-1];
   always_ff @(posedge clk) begin
      if (en) begin
         for (int k = 0; k < N; k++) begin
            ra[k] <= xa[k];
            rb[k] <= xb[k];
            rs[k] <= ns[k];
            rc[k] <= seg_c[k];
            rm[k] <= xm[k];
            rmsb[k] <= xmsb[k];
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         s <= '0;
         cout <= 1'b0;
         ovf <= 1'b0;
      end else if (en) begin
         vld <= vsh[N-1:0];
         s <= sat_s;
         cout <= seg_c[N-1];
         ovf <= (xm[N-1] == MODE_USAT) ? seg_c[N-1] : v;
      end
   end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed vector table plus stall, stream and reset sequences
module tb_pipelined_cla_adder;
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [1:0]  mode;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
   logic in_ready, out_valid, cout, ovf;
   logic [15:0] a = '0, b = '0, s;
   logic [1:0] mode = '0;
   int ncmp = 0, nbad = 0;
   vec_t vt [13];
   pipelined_cla_adder #(.WIDTH(16), .SEG_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic vec_t model(input vec_t t);
      logic [16:0] f;
      logic vv;
      f = {1'b0, t.a} + {1'b0, t.b} + 17'(t.cin);
      vv = (t.a[15] == t.b[15]) && (f[15] != t.a[15]);
      t.cout = f[16];
      t.ovf = (t.mode == 2'b10) ? f[16] : vv;
      t.s = (t.mode == 2'b01 && vv) ? (t.a[15] ? 16'h8000 : 16'h7FFF) :
            (t.mode == 2'b10 && f[16]) ? 16'hFFFF : f[15:0];
      return t;
   endfunction
   task automatic drive(input vec_t t);
      a = t.a;
      b = t.b;
      cin = t.cin;
      mode = t.mode;
   endtask
   task automatic wait_valid(input string nm, output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, ".latency"}, lat, 4);
   endtask
   task automatic run_one(input vec_t t, input string nm);
      int lat;
      @(negedge clk);
      drive(t);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(nm, lat);
      chk({nm, ".s"}, s, t.s);
      chk({nm, ".cout"}, cout, t.cout);
      chk({nm, ".ovf"}, ovf, t.ovf);
   endtask
   task automatic stream(input int n, input bit rnd, input string nm);
      vec_t q [$];
      vec_t cur, e;
      int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
      bit acc = 1'b0;
      cur = '0;
      while (got < n && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (acc) in_valid = 1'b0;
         acc = 1'b0;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!in_valid && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
            cur.a = 16'($urandom);
            cur.b = 16'($urandom);
            cur.cin = 1'($urandom_range(0, 1));
            cur.mode = 2'($urandom_range(0, 3));
            drive(cur);
            in_valid = 1'b1;
         end
         #1;
         chk({nm, ".in_ready"}, in_ready, !out_valid || out_ready);
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk({nm, ".spurious"}, 1, 0);
            else begin
               e = q.pop_front();
               chk({nm, ".s"}, s, e.s);
               chk({nm, ".cout"}, cout, e.cout);
               chk({nm, ".ovf"}, ovf, e.ovf);
            end
            got++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (in_valid && in_ready) begin
            q.push_back(model(cur));
            sent++;
            acc = 1'b1;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk({nm, ".count"}, got, n);
      chk({nm, ".leftover"}, q.size(), 0);
      if (!rnd) chk({nm, ".throughput"}, last - first, n - 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      int lat;
      bit seen;
      vt[0]  = '{16'h00FF, 16'h0001, 1'b0, 2'b00, 16'h0100, 1'b0, 1'b0};
      vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 2'b00, 16'h8000, 1'b0, 1'b1};
      vt[2]  = '{16'h7FFF, 16'h0001, 1'b0, 2'b01, 16'h7FFF, 1'b0, 1'b1};
      vt[3]  = '{16'h8000, 16'hFFFF, 1'b0, 2'b01, 16'h8000, 1'b1, 1'b1};
      vt[4]  = '{16'h8000, 16'hFFFF, 1'b0, 2'b10, 16'hFFFF, 1'b1, 1'b1};
      vt[5]  = '{16'hFFFF, 16'h0000, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0};
      vt[6]  = '{16'h8000, 16'h8000, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b1};
      vt[7]  = '{16'h8000, 16'h8000, 1'b0, 2'b01, 16'h8000, 1'b1, 1'b1};
      vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 2'b10, 16'hFFFF, 1'b1, 1'b1};
      vt[9]  = '{16'h1234, 16'h4321, 1'b0, 2'b11, 16'h5555, 1'b0, 1'b0};
      vt[10] = '{16'h7000, 16'h1000, 1'b0, 2'b11, 16'h8000, 1'b0, 1'b1};
      vt[11] = '{16'h0001, 16'hFFFE, 1'b0, 2'b10, 16'hFFFF, 1'b0, 1'b0};
      vt[12] = '{16'h7FFF, 16'h7FFF, 1'b1, 2'b01, 16'h7FFF, 1'b0, 1'b1};
      @(negedge clk);
      @(negedge clk);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.s", s, 0);
      chk("rst.cout", cout, 0);
      chk("rst.ovf", ovf, 0);
      chk("rst.in_ready", in_ready, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 13; i++) run_one(vt[i], $sformatf("vec%0d", i));
      // stalled result must hold and block input until taken
      @(negedge clk);
      drive(vt[3]);
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid("stall", lat);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall.out_valid", out_valid, 1);
         chk("stall.in_ready", in_ready, 0);
         chk("stall.s", s, vt[3].s);
         chk("stall.ovf", ovf, vt[3].ovf);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall.drained", out_valid, 0);
      stream(20, 1'b1, "rand");
      stream(8, 1'b0, "burst");
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(vt[i]);
         in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("rstmid.full", out_valid, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid.out_valid", out_valid, 0);
      chk("rstmid.s", s, 0);
      chk("rstmid.cout", cout, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen |= out_valid;
      end
      chk("rstmid.stale", seen, 0);
      run_one(vt[12], "post_rst");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder for the neural-network datapath, used as the accumulate/bias-add element behind the multipliers.
- Splits a WIDTH-bit add into NUM_SEG = WIDTH/SEG_WIDTH lookahead segments, one segment per pipeline stage. Carry is registered between stages.
- Adds carry-in, carry-out, overflow flag and per-transaction wrap/saturate mode.
- Uses valid/ready flow control on both sides.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of SEG_WIDTH.
SEG_WIDTH, 4, bits resolved per stage by one lookahead segment; NUM_SEG = WIDTH/SEG_WIDTH >= 1.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand transaction present.
in_ready  out  1  block accepts transaction this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in to bit 0.
mode  in  2  00 wrap, 01 signed saturate, 10 unsigned saturate, 11 treated as wrap.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts result.
s  out  WIDTH  sum, after saturation if selected.
cout  out  1  raw carry out of MSB, before saturation.
ovf  out  1  signed overflow in mode 01; carry out in mode 10; raw signed overflow in modes 00/11.

Behaviour:
Reset and handshake
- Reset is asynchronous and active-low on rst_n, single clock clk.
- During reset, all stage valid bits clear; out_valid=0, s=0, cout=0, ovf=0.
- Global advance enable: en = !out_valid || out_ready. in_ready = en, combinational.
- Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
- When en=0, every stage holds: no loss, no duplication, order preserved.
- Bubbles are not compressed: each stage's valid bit shifts with en.

Latency and datapath
- Latency is NUM_SEG cycles from accept to out_valid, assuming no stall.
- Full throughput: one result per cycle while out_ready=1.
- Stage k (0..NUM_SEG-1) computes bits [k*SEG_WIDTH +: SEG_WIDTH] using G=a&b, P=a^b, flat lookahead carries, and cin_k:
  - cin_0 = cin; cin_k = registered carry-out of stage k-1.
- Operand bits not yet consumed travel forward in skew registers. Computed sum bits are registered forward.
- mode travels with the transaction.
- Last stage also captures c_msb (carry into the MSB) and cout.

Saturation, applied at the output register
- Raw overflow: v = c_msb ^ cout.
- Mode 01 with v=1: s = 0111..1 if a[MSB]=0, else 1000..0 (MSB of the original operand, carried in the skew path).
- Mode 10 with cout=1: s = all ones.
- Otherwise s = raw sum mod 2^WIDTH.

Boundary cases
- NUM_SEG=1 degenerates to a single registered stage with latency 1.
- Simultaneous in-transfer and out-transfer in the same cycle is legal and keeps full throughput.
- out_ready may change while out_valid=1; s, cout and ovf stay stable until transfer.
- Reset asserted mid-operation discards all in-flight transactions immediately; nothing is emitted for them after release.
- in_valid must not depend on in_ready; the reverse dependency is allowed.

Decomposition:
Shared package: mode encodings (MODE_WRAP, MODE_SSAT, MODE_USAT) and a function computing NUM_SEG. Parameter legality is checked by an elaboration-time assertion in the top module.
Sub-module cla_segment, combinational:
- Ports: SEG_WIDTH a, b, cin; outputs sum, cout, c_msb.
- Built from per-bit G/P and flat lookahead carry equations.
- Instantiated NUM_SEG times by a generate loop.
Top holds the pipeline registers, the skew registers, the valid chain and the saturation logic.

Test Plan:
All scenarios use WIDTH=16, SEG_WIDTH=4, latency 4.
1. a=0x00FF, b=0x0001, cin=0, mode=00 -> s=0x0100, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
2. a=0x7FFF, b=0x0001, cin=0 -> mode 00: s=0x8000, ovf=1; mode 01: s=0x7FFF, ovf=1.
3. a=0x8000, b=0xFFFF -> mode 01: s=0x8000, ovf=1, cout=1; mode 10: s=0xFFFF, ovf=1.
4. a=0xFFFF, b=0x0000, cin=1, mode=00 -> s=0x0000, cout=1, ovf=0; carry ripples through all four stage registers.
5. Stream 20 random transactions, out_ready toggling randomly -> results match the golden model in order, no drops or duplicates; in_ready=0 whenever out_valid=1 and out_ready=0.
6. Three transactions in flight, pulse rst_n low for one cycle -> out_valid=0 asynchronously; no stale result appears after release; next transaction returns correct sum at latency 4.
